// File: rtl/alu_rf_pipe.sv
// ---------------------------------------------------------------------------
// alu_rf_pipe
//
// Pipelined ALU datapath with an integrated NREGS x DATA_WIDTH register file.
// An accepted instruction reads two source registers into the EX stage. One
// edge later it executes one of eight ALU ops. The result goes to a
// valid/ready output register and, optionally, back into the register file.
//
// Configuration macro:
//   ALU_RF_FORWARDING_EN  defined   : EX result is bypassed to a dependent
//                                     incoming instruction, never stalls.
//                         undefined : a dependent instruction stalls for one
//                                     cycle until the writeback has landed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid_i/ready_o  instruction handshake
//   op_i                opcode (ADD SUB AND OR XOR SLL SRL SRA)
//   rs_a_i, rs_b_i      source register addresses
//   rd_i, wb_en_i       destination address and writeback enable
//   ext_we_i/wready_o   external register-file write handshake
//   ext_waddr_i/wdata_i external write address and data
//   dbg_raddr_i/rdata_o combinational debug read port (pre-edge contents)
//   res_valid_o/ready_i result handshake
//   res_data_o          result data
//   res_carry_o         carry (ADD) / no-borrow (SUB), 0 for other ops
//   res_zero_o          res_data_o == 0
// ---------------------------------------------------------------------------
module alu_rf_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 32,
  localparam int ADDR_WIDTH = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] rs_a_i,
  input  logic [ADDR_WIDTH-1:0] rs_b_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  wb_en_i,
  input  logic                  ext_we_i,
  input  logic [ADDR_WIDTH-1:0] ext_waddr_i,
  input  logic [DATA_WIDTH-1:0] ext_wdata_i,
  output logic                  ext_wready_o,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr_i,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_carry_o,
  output logic                  res_zero_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  // Register file
  logic [DATA_WIDTH-1:0] rf_q [NREGS];

  // EX stage
  logic                  ex_valid_q, ex_valid_d;
  op_e                   ex_op_q, ex_op_d;
  logic [DATA_WIDTH-1:0] ex_a_q, ex_a_d;
  logic [DATA_WIDTH-1:0] ex_b_q, ex_b_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_wb_en_q, ex_wb_en_d;

  // Output register
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_carry_q, res_carry_d;
  logic                  res_zero_q, res_zero_d;

  // ALU and control
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_carry;
  logic [SHW-1:0]        shamt;
  logic                  advance;
  logic                  wb_we;
  logic                  stall;
  logic                  accept;
  logic                  ext_fire;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;

  assign shamt = ex_b_q[SHW-1:0];

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum       = '0;
    alu_data  = '0;
    alu_carry = 1'b0;
    case (ex_op_q)
      OP_ADD: begin
        sum                 = {1'b0, ex_a_q} + {1'b0, ex_b_q};
        {alu_carry, alu_data} = sum;
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is the "no borrow" flag.
        sum                 = {1'b0, ex_a_q} + {1'b0, ~ex_b_q} + (DATA_WIDTH+1)'(1);
        {alu_carry, alu_data} = sum;
      end
      OP_AND: alu_data = ex_a_q & ex_b_q;
      OP_OR:  alu_data = ex_a_q | ex_b_q;
      OP_XOR: alu_data = ex_a_q ^ ex_b_q;
      OP_SLL: alu_data = ex_a_q << shamt;
      OP_SRL: alu_data = ex_a_q >> shamt;
      OP_SRA: alu_data = DATA_WIDTH'($signed(ex_a_q) >>> shamt);
      default: alu_data = '0;
    endcase
  end

  // EX retires whenever the output register is empty or being drained.
  assign advance  = ex_valid_q & (~res_valid_q | res_ready_i);
  assign wb_we    = advance & ex_wb_en_q;

`ifdef ALU_RF_FORWARDING_EN
  assign stall  = 1'b0;
  assign opnd_a = (wb_we && rs_a_i == ex_rd_q) ? alu_data : rf_q[rs_a_i];
  assign opnd_b = (wb_we && rs_b_i == ex_rd_q) ? alu_data : rf_q[rs_b_i];
`else
  // Hold a dependent instruction until the producer's writeback has landed.
  assign stall  = ex_valid_q & ex_wb_en_q & ((rs_a_i == ex_rd_q) | (rs_b_i == ex_rd_q));
  assign opnd_a = rf_q[rs_a_i];
  assign opnd_b = rf_q[rs_b_i];
`endif

  assign in_ready_o   = (~ex_valid_q | advance) & ~stall;
  assign accept       = in_valid_i & in_ready_o;
  // The single RF write port belongs to the pipeline on a writeback edge.
  assign ext_wready_o = ~wb_we;
  assign ext_fire     = ext_we_i & ext_wready_o;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_rd_d     = ex_rd_q;
    ex_wb_en_d  = ex_wb_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;

    if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = op_e'(op_i);
      ex_a_d     = opnd_a;
      ex_b_d     = opnd_b;
      ex_rd_d    = rd_i;
      ex_wb_en_d = wb_en_i;
    end else if (advance) begin
      ex_valid_d = 1'b0;
    end

    if (advance) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_data;
      res_carry_d = alu_carry;
      res_zero_d  = (alu_data == '0);
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b1;
    end else begin
      ex_valid_q  <= ex_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
    end
  end

  // EX payload is qualified by ex_valid_q and needs no reset.
  always_ff @(posedge clk) begin
    ex_op_q    <= ex_op_d;
    ex_a_q     <= ex_a_d;
    ex_b_q     <= ex_b_d;
    ex_rd_q    <= ex_rd_d;
    ex_wb_en_q <= ex_wb_en_d;
  end

  // NOTE: this register file must come out of reset all-zero, so it is reset
  // entry by entry and maps to flops rather than a RAM macro.
  // A pipeline writeback is dropped under reset, but an external write that
  // completes its handshake on the reset edge still lands. The later
  // non-blocking assignment wins over the reset clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[ex_rd_q] <= alu_data;
    end
    if (ext_fire) rf_q[ext_waddr_i] <= ext_wdata_i;
  end

  assign dbg_rdata_o = rf_q[dbg_raddr_i];
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_carry_o = res_carry_q;
  assign res_zero_o  = res_zero_q;

endmodule
